systolic_out_drain_ctrl: RTL and testbench



---
 rtl/systolic_out_drain_ctrl_if.sv | 32 +++
 rtl/systolic_out_drain_ctrl.sv | 99 +++++++++
 tb/tb_systolic_out_drain_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_out_drain_ctrl_if.sv
// Handshake and data bundle between the drain controller, the systolic result lanes,
// the per-row output FIFOs and the writeback port.
interface systolic_out_drain_ctrl_if #(
  parameter int array_dim = 4,
  parameter int data_w    = 16,
  parameter int addr_w    = 8
);
  logic                                  start;
  logic [addr_w-1:0]                     base_addr;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [array_dim*data_w-1:0]           in_data;
  logic                                  fifo_shift;
  logic [array_dim*data_w-1:0]           fifo_value;
  logic [array_dim*array_dim*data_w-1:0] fifo_out;
  logic                                  wb_valid;
  logic                                  wb_ready;
  logic [addr_w-1:0]                     wb_addr;
  logic [array_dim*data_w-1:0]           wb_data;
  logic                                  busy;
  logic                                  done;

  modport master (
    input  start, base_addr, in_valid, in_data, fifo_out, wb_ready,
    output in_ready, fifo_shift, fifo_value, wb_valid, wb_addr, wb_data, busy, done
  );

  modport slave (
    output start, base_addr, in_valid, in_data, fifo_out, wb_ready,
    input  in_ready, fifo_shift, fifo_value, wb_valid, wb_addr, wb_data, busy, done
  );
endinterface

// File: rtl/systolic_out_drain_ctrl.sv
// Drains one result tile into the per-row output FIFOs (FILL), then writes the
// tile back one row per handshake (WRITE), pulsing done once the last row is taken.
module systolic_out_drain_ctrl #(
  parameter int array_dim = 4,
  parameter int data_w    = 16,
  parameter int addr_w    = 8
) (
  input logic                     CLK,
  input logic                     nRST,
  systolic_out_drain_ctrl_if.master bus
);
  localparam int RowW = array_dim * data_w;
  localparam int CntW = (array_dim > 1) ? $clog2(array_dim) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(array_dim - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0]   row_cnt_q, row_cnt_d;
  logic [addr_w-1:0] base_q, base_d;
  logic              done_q, done_d;
  logic              accept;
  logic              wb_hs;
  logic [RowW-1:0]   fifo_slice [array_dim];

  for (genvar i = 0; i < array_dim; i++) begin : g_slice
    assign fifo_slice[i] = bus.fifo_out[i*RowW +: RowW];
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
      base_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      row_cnt_q  <= row_cnt_d;
      base_q     <= base_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    row_cnt_d    = row_cnt_q;
    base_d       = base_q;
    done_d       = 1'b0;
    bus.in_ready = (state_q == FILL);
    bus.wb_valid = (state_q == WRITE);
    accept       = bus.in_valid & bus.in_ready;
    wb_hs        = bus.wb_valid & bus.wb_ready;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = FILL;
          base_d     = bus.base_addr;
          beat_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (beat_cnt_q == LastIdx) begin
            state_d    = WRITE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end
      end
      WRITE: begin
        // Row counter wraps back to 0 so the next tile starts from row 0.
        if (wb_hs) begin
          if (row_cnt_q == LastIdx) begin
            state_d   = IDLE;
            row_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_shift = accept;
  assign bus.fifo_value = bus.in_data;
  assign bus.wb_addr    = base_q + addr_w'(row_cnt_q);
  assign bus.wb_data    = fifo_slice[row_cnt_q];
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_systolic_out_drain_ctrl.sv
// Directed bench for systolic_out_drain_ctrl with a behavioural model of the four
// output FIFOs so that writeback rows carry real drained data.
module tb_systolic_out_drain_ctrl;
  logic CLK;
  logic nRST;
  int   vecCount;
  int   missCount;

  systolic_out_drain_ctrl_if #(.array_dim(4), .data_w(16), .addr_w(8)) bus ();

  systolic_out_drain_ctrl #(.array_dim(4), .data_w(16), .addr_w(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output FIFO model: entry 0 holds the newest value, out slice j = entry j.
  logic [15:0] fifoMem [4][4];

  always @(posedge CLK) begin
    if (bus.fifo_shift) begin
      for (int i = 0; i < 4; i++) begin
        fifoMem[i][0] <= bus.fifo_value[i*16 +: 16];
        for (int j = 1; j < 4; j++) fifoMem[i][j] <= fifoMem[i][j-1];
      end
    end
  end

  always_comb begin
    bus.fifo_out = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        bus.fifo_out[i*64 + j*16 +: 16] = fifoMem[i][j];
  end

  function automatic logic [15:0] elem(input int t, input int k, input int i);
    return {4'hA, 4'(t), 4'(k), 4'(i)};
  endfunction

  function automatic logic [63:0] column(input int t, input int k);
    logic [63:0] c;
    for (int i = 0; i < 4; i++) c[i*16 +: 16] = elem(t, k, i);
    return c;
  endfunction

  // Row r of a drained tile: oldest column in the top lane, newest in the bottom lane.
  function automatic logic [63:0] expRow(input int t, input int r);
    logic [63:0] v;
    for (int k = 0; k < 4; k++) v[(3-k)*16 +: 16] = elem(t, k, r);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".in_ready"},   64'(bus.in_ready),   64'd0);
    checkOutput({tag, ".fifo_shift"}, 64'(bus.fifo_shift), 64'd0);
    checkOutput({tag, ".wb_valid"},   64'(bus.wb_valid),   64'd0);
    checkOutput({tag, ".wb_addr"},    64'(bus.wb_addr),    64'd0);
    checkOutput({tag, ".busy"},       64'(bus.busy),       64'd0);
    checkOutput({tag, ".done"},       64'(bus.done),       64'd0);
  endtask

  task automatic checkWrite(input string tag, input logic [7:0] expAddr, input logic [63:0] expData);
    checkOutput({tag, ".wb_valid"},   64'(bus.wb_valid),   64'd1);
    checkOutput({tag, ".wb_addr"},    64'(bus.wb_addr),    64'(expAddr));
    checkOutput({tag, ".wb_data"},    bus.wb_data,         expData);
    checkOutput({tag, ".fifo_shift"}, 64'(bus.fifo_shift), 64'd0);
    checkOutput({tag, ".in_ready"},   64'(bus.in_ready),   64'd0);
    checkOutput({tag, ".busy"},       64'(bus.busy),       64'd1);
    checkOutput({tag, ".done"},       64'(bus.done),       64'd0);
  endtask

  // Pull nRST low for one edge, then confirm reset values and that no done follows.
  task automatic doAbort();
    step();
    nRST = 1'b0;
    bus.in_valid = 1'b1;
    bus.wb_ready = 1'b0;
    bus.start = 1'b0;
    #1;
    step();
    nRST = 1'b1;
    #1;
    checkResetState("abort");
    for (int n = 0; n < 3; n++) begin
      step();
      bus.in_valid = 1'b0;
      #1;
      checkOutput("abortNoDone", 64'(bus.done), 64'd0);
      checkOutput("abortIdle", 64'(bus.busy | bus.wb_valid), 64'd0);
    end
  endtask

  task automatic applyStimulus(input int tileId, input logic [7:0] base, input bit stallMode,
                               input int wbStall, input bit busyStart, input bit startAlready,
                               input bit chainStart, input logic [7:0] nextBase,
                               input int abortBeats, input int abortRows, input int expLatency);
    int          cyc;
    int          beats;
    int          k;
    int          shifts;
    logic        v;
    logic [6:0]  pat;
    logic [7:0]  expAddr;
    logic [63:0] row;
    pat    = 7'b1011001;
    cyc    = 0;
    beats  = 0;
    k      = 0;
    shifts = 0;
    if (!startAlready) begin
      step();
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.in_valid  = 1'b0;
      bus.wb_ready  = 1'b0;
      #1;
      checkOutput("startBusy", 64'(bus.busy), 64'd0);
      checkOutput("startInReady", 64'(bus.in_ready), 64'd0);
    end
    while (beats < 4) begin
      if (beats == abortBeats) begin
        doAbort();
        return;
      end
      if (k >= 40) begin
        checkOutput("fillTimeout", 64'(beats), 64'd4);
        return;
      end
      step();
      cyc++;
      v            = stallMode ? pat[k % 7] : 1'b1;
      bus.start    = busyStart;
      bus.in_valid = v;
      bus.in_data  = column(tileId, beats);
      #1;
      checkOutput("fillInReady", 64'(bus.in_ready), 64'd1);
      checkOutput("fillShift", 64'(bus.fifo_shift), 64'(v));
      checkOutput("fillValue", bus.fifo_value, column(tileId, beats));
      checkOutput("fillBusy", 64'(bus.busy), 64'd1);
      checkOutput("fillWbValid", 64'(bus.wb_valid), 64'd0);
      if (bus.fifo_shift) shifts++;
      if (v) beats++;
      k++;
    end
    checkOutput("shiftCount", 64'(shifts), 64'd4);
    for (int r = 0; r < 4; r++) begin
      if (r == abortRows) begin
        doAbort();
        return;
      end
      expAddr = base + 8'(r);
      row     = expRow(tileId, r);
      for (int s = 0; s < wbStall; s++) begin
        step();
        cyc++;
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.start    = busyStart;
        #1;
        checkWrite("wbStall", expAddr, row);
      end
      step();
      cyc++;
      bus.wb_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.start    = busyStart;
      #1;
      checkWrite("wbRow", expAddr, row);
    end
    step();
    cyc++;
    bus.wb_ready  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.start     = chainStart;
    bus.base_addr = nextBase;
    #1;
    checkOutput("donePulse", 64'(bus.done), 64'd1);
    checkOutput("doneBusy", 64'(bus.busy), 64'd0);
    checkOutput("doneWbValid", 64'(bus.wb_valid), 64'd0);
    checkOutput("doneLatency", 64'(cyc), 64'(expLatency));
    if (!chainStart) begin
      step();
      bus.start = 1'b0;
      #1;
      checkOutput("postDone", 64'(bus.done), 64'd0);
      checkOutput("postBusy", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecCount      = 0;
    missCount     = 0;
    nRST          = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.wb_ready  = 1'b0;
    step();
    step();
    checkResetState("reset");
    step();
    nRST = 1'b1;
    #1;
    checkResetState("idle");

    // tile, base, stallMode, wbStall, busyStart, startAlready, chain, nextBase, abortBeats, abortRows, latency
    applyStimulus(1, 8'h10, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, 9);
    applyStimulus(2, 8'h20, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, 12);
    applyStimulus(3, 8'h30, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, 21);
    applyStimulus(4, 8'hFE, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'h40, -1, -1, 9);
    applyStimulus(5, 8'h40, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, -1, -1, 9);
    applyStimulus(6, 8'h50, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00,  2, -1, 0);
    applyStimulus(7, 8'h60, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, 9);
    applyStimulus(8, 8'h70, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, -1,  1, 0);
    applyStimulus(9, 8'h80, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
